mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 51 +++++
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Two requester ports plus the memory-side bus of the arbiter.
// 'byte' is a reserved word, so the memory byte-access control is carried as mem_byte.
interface mem_arbiter_if #(
   parameter int AW = 32
);
   // port 0: CPU
   logic          req0;
   logic [AW-1:0] addr0;
   logic [31:0]   wdata0;
   logic          rw0;
   logic          byte0;
   // port 1: loader
   logic          req1;
   logic [AW-1:0] addr1;
   logic [31:0]   wdata1;
   logic          rw1;
   logic          byte1;
   // per-port status
   logic          gnt0;
   logic          gnt1;
   logic          done0;
   logic          done1;
   logic          err0;
   logic          err1;
   logic [31:0]   rdata;
   logic          busy;
   // memory side
   logic [AW-1:0] memAdress;
   logic [31:0]   memDataOut;
   logic          rw;
   logic          mem_byte;
   logic          memEnable;
   logic          MOC;
   logic [31:0]   memData;

   modport slave (
      input  req0, addr0, wdata0, rw0, byte0,
      input  req1, addr1, wdata1, rw1, byte1,
      input  MOC, memData,
      output gnt0, gnt1, done0, done1, err0, err1, rdata, busy,
      output memAdress, memDataOut, rw, mem_byte, memEnable
   );

   modport master (
      output req0, addr0, wdata0, rw0, byte0,
      output req1, addr1, wdata1, rw1, byte1,
      output MOC, memData,
      input  gnt0, gnt1, done0, done1, err0, err1, rdata, busy,
      input  memAdress, memDataOut, rw, mem_byte, memEnable
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving a CPU port and a loader port exclusive use of one memory,
// with a per-access timeout; grant->done takes MOC latency, release waits for MOC to fall.
module mem_arbiter #(
   parameter int TIMEOUT = 15,
   parameter int AW      = 32
) (
   input  logic          clk,
   input  logic          reset,
   mem_arbiter_if.slave  bus
);
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_RELEASE
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          last_gnt_q, last_gnt_d;
   logic [1:0]    gnt_q, gnt_d;
   logic [1:0]    done_q, done_d;
   logic [1:0]    err_q, err_d;
   logic [31:0]   rdata_q, rdata_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          rw_q, rw_d;
   logic          byte_q, byte_d;
   logic          en_q, en_d;
   logic          busy_q, busy_d;
   logic          pick1;

   // Port 1 wins when alone, or when contested and port 0 held the last grant.
   assign pick1 = bus.req1 & (~bus.req0 | ~last_gnt_q);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_gnt_d = last_gnt_q;
      gnt_d      = gnt_q;
      done_d     = 2'b00;
      err_d      = 2'b00;
      rdata_d    = rdata_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rw_d       = rw_q;
      byte_d     = byte_q;
      en_d       = en_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.req0 | bus.req1) begin
               last_gnt_d = pick1;
               addr_d     = pick1 ? bus.addr1  : bus.addr0;
               wdata_d    = pick1 ? bus.wdata1 : bus.wdata0;
               rw_d       = pick1 ? bus.rw1    : bus.rw0;
               byte_d     = pick1 ? bus.byte1  : bus.byte0;
               gnt_d      = pick1 ? 2'b10 : 2'b01;
               en_d       = 1'b1;
               cnt_d      = '0;
               state_d    = S_ACCESS;
            end
         end
         S_ACCESS: begin
            // MOC takes priority over the timeout on the same edge.
            if (bus.MOC) begin
               if (!rw_q) begin
                  rdata_d = bus.memData;
               end
               done_d  = gnt_q;
               en_d    = 1'b0;
               state_d = S_RELEASE;
            end else if (cnt_q == CNT_LAST) begin
               done_d  = gnt_q;
               err_d   = gnt_q;
               en_d    = 1'b0;
               state_d = S_RELEASE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RELEASE: begin
            if (!bus.MOC) begin
               gnt_d   = 2'b00;
               state_d = S_IDLE;
            end
         end
         default: begin
            gnt_d   = 2'b00;
            en_d    = 1'b0;
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         last_gnt_q <= 1'b1;
         gnt_q      <= 2'b00;
         done_q     <= 2'b00;
         err_q      <= 2'b00;
         rdata_q    <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rw_q       <= 1'b0;
         byte_q     <= 1'b0;
         en_q       <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_gnt_q <= last_gnt_d;
         gnt_q      <= gnt_d;
         done_q     <= done_d;
         err_q      <= err_d;
         rdata_q    <= rdata_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rw_q       <= rw_d;
         byte_q     <= byte_d;
         en_q       <= en_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.gnt0       = gnt_q[0];
   assign bus.gnt1       = gnt_q[1];
   assign bus.done0      = done_q[0];
   assign bus.done1      = done_q[1];
   assign bus.err0       = err_q[0];
   assign bus.err1       = err_q[1];
   assign bus.rdata      = rdata_q;
   assign bus.busy       = busy_q;
   assign bus.memAdress  = addr_q;
   assign bus.memDataOut = wdata_q;
   assign bus.rw         = rw_q;
   assign bus.mem_byte   = byte_q;
   assign bus.memEnable  = en_q;
endmodule
